// File: rtl/array_div_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// master drives operands and result acceptance; slave is the divider.
interface array_div_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div0;
  logic           exact;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div0, exact
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div0, exact
  );
endinterface

// File: rtl/array_div_seq.sv
// Sequential restoring divider (2N-bit dividend / N-bit divisor), one quotient bit per clock.
// Optional macro ARRAY_DIV_EXACT_CHK_EN builds the exact-product flag; otherwise exact is tied low.
module array_div_seq #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  array_div_if.slave  bus
);
  localparam int W2    = 2 * N;
  localparam int CNT_W = $clog2(W2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    work;     // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [N-1:0]     dvs;
  logic [N-1:0]     rem;
  logic [N-1:0]     rem_out;
  logic             div0_r;
  logic             in_ready_c;
  logic             out_valid_c;
  logic [N:0]       t;
  logic             q_bit;
  logic [N-1:0]     rem_nxt;
  logic [W2-1:0]    work_nxt;

  // Partial remainder after a restoring subtract; always fits N bits since it is < divisor.
  function automatic logic [N-1:0] restore_step(input logic [N:0] tv, input logic [N-1:0] d);
    if (tv >= {1'b0, d}) return N'(tv - {1'b0, d});
    else                 return tv[N-1:0];
  endfunction

  assign t        = {rem, work[W2-1]};
  assign q_bit    = (t >= {1'b0, dvs});
  assign rem_nxt  = restore_step(t, dvs);
  assign work_nxt = {work[W2-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      dvs     <= '0;
      rem     <= '0;
      rem_out <= '0;
      div0_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvs     <= bus.divisor;
            rem     <= '0;
            cnt     <= CNT_W'(W2 - 1);
            rem_out <= '0;
            if (bus.divisor == '0) begin
              work   <= '1;
              div0_r <= 1'b1;
            end else begin
              work   <= bus.dividend;
              div0_r <= 1'b0;
            end
          end
        end
        CALC: begin
          work <= work_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) rem_out <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef ARRAY_DIV_EXACT_CHK_EN
  logic exact_r;

  // Exact N x N product: zero remainder and the recovered operand fits in N bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      exact_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      exact_r <= 1'b0;
    end else if (state == CALC && cnt == '0) begin
      exact_r <= (rem_nxt == '0) && (work_nxt[W2-1:N] == '0);
    end
  end

  assign bus.exact = exact_r;
`else
  assign bus.exact = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.quotient  = work;
  assign bus.remainder = rem_out;
  assign bus.div0      = div0_r;
endmodule

// File: tb/tb_array_div_seq.sv
// Scoreboard bench for array_div_seq: directed cases, backpressure, mid-calc reset, exhaustive sweep.
module tb_array_div_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_div_if #(.N(N)) bus ();
  array_div_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       d0;
    logic       ex;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic res_t model(input logic [7:0] d, input logic [3:0] v);
    res_t e;
    if (v == 4'd0) begin
      e.q = 8'hFF; e.r = 4'd0; e.d0 = 1'b1; e.ex = 1'b0;
    end else begin
      e.q  = d / {4'd0, v};
      e.r  = 4'(d % {4'd0, v});
      e.d0 = 1'b0;
`ifdef ARRAY_DIV_EXACT_CHK_EN
      e.ex = (e.r == 4'd0) && (e.q[7:4] == 4'd0);
`else
      e.ex = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] v, output bit to);
    int n = 0;
    to = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = d;
    bus.divisor  = v;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      to = 1'b1;
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(model(d, v));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
    end
  endtask

  task automatic recv(input int stall, output res_t got, output int lat, output bit to);
    int n = 0;
    to = 1'b0;
    got = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 40) begin
        to = 1'b1;
        break;
      end
    end
    lat = n + 1;
    if (!to) begin
      repeat (stall) @(negedge clk);
      got.q  = bus.quotient;
      got.r  = bus.remainder;
      got.d0 = bus.div0;
      got.ex = bus.exact;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00) begin failures++; $display("FAIL reset_quotient got=%h exp=00", bus.quotient); end
    checks++; if (bus.remainder !== 4'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", bus.remainder); end
    checks++; if (bus.div0 !== 1'b0)      begin failures++; $display("FAIL reset_div0 got=%b exp=0", bus.div0); end
    checks++; if (bus.exact !== 1'b0)     begin failures++; $display("FAIL reset_exact got=%b exp=0", bus.exact); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] dv [3] = '{8'hB6, 8'h2D, 8'hFF};
    logic [3:0] vv [3] = '{4'hD, 4'h7, 4'h1};
    res_t got, exp;
    int   lat;
    bit   to;
    for (int i = 0; i < 3; i++) begin
      send(dv[i], vv[i], to);
      checks++;
      if (to) begin failures++; $display("FAIL basic_send_timeout case=%0d", i); continue; end
      recv(0, got, lat, to);
      exp = sb.pop_front();
      checks++;
      if (to) begin failures++; $display("FAIL basic_recv_timeout case=%0d", i); continue; end
      checks++; if (lat !== 9)     begin failures++; $display("FAIL basic_latency case=%0d got=%0d exp=9", i, lat); end
      checks++; if (got.q !== exp.q)   begin failures++; $display("FAIL basic_quotient case=%0d got=%h exp=%h", i, got.q, exp.q); end
      checks++; if (got.r !== exp.r)   begin failures++; $display("FAIL basic_remainder case=%0d got=%h exp=%h", i, got.r, exp.r); end
      checks++; if (got.d0 !== exp.d0) begin failures++; $display("FAIL basic_div0 case=%0d got=%b exp=%b", i, got.d0, exp.d0); end
      checks++; if (got.ex !== exp.ex) begin failures++; $display("FAIL basic_exact case=%0d got=%b exp=%b", i, got.ex, exp.ex); end
    end
  endtask

  task automatic test_div0();
    res_t got, exp;
    int   lat;
    bit   to;
    send(8'h55, 4'h0, to);
    checks++;
    if (to) begin failures++; $display("FAIL div0_send_timeout"); return; end
    recv(0, got, lat, to);
    exp = sb.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL div0_recv_timeout"); return; end
    checks++; if (lat !== 1)         begin failures++; $display("FAIL div0_latency got=%0d exp=1", lat); end
    checks++; if (got.q !== exp.q)   begin failures++; $display("FAIL div0_quotient got=%h exp=%h", got.q, exp.q); end
    checks++; if (got.r !== exp.r)   begin failures++; $display("FAIL div0_remainder got=%h exp=%h", got.r, exp.r); end
    checks++; if (got.d0 !== exp.d0) begin failures++; $display("FAIL div0_flag got=%b exp=%b", got.d0, exp.d0); end
    checks++; if (got.ex !== exp.ex) begin failures++; $display("FAIL div0_exact got=%b exp=%b", got.ex, exp.ex); end
  endtask

  task automatic test_backpressure();
    res_t exp;
    int   n = 0;
    bit   to;
    bit   bad_seen = 1'b0;
    send(8'h2D, 4'h7, to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_send_timeout"); return; end
    exp = sb.pop_front();
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!bus.out_valid) begin failures++; $display("FAIL bp_wait_timeout"); return; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.quotient, bus.remainder, bus.div0, bus.exact} !== exp ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got q=%h r=%h d0=%b ex=%b rdy=%b vld=%b exp q=%h r=%h d0=%b ex=%b rdy=0 vld=1",
                 i, bus.quotient, bus.remainder, bus.div0, bus.exact, bus.in_ready, bus.out_valid,
                 exp.q, exp.r, exp.d0, exp.ex);
      end
      if (i == 1) begin bus.in_valid = 1'b1; bus.dividend = 8'h11; bus.divisor = 4'h3; end
      if (i == 3) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL bp_in_ready_after got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_out_valid_after got=%b exp=0", bus.out_valid); end
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad_seen = 1'b1;
    end
    checks++; if (bad_seen) begin failures++; $display("FAIL bp_pulse_ignored got=busy exp=idle"); end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    int   lat;
    bit   to;
    bit   bad_seen = 1'b0;
    send(8'h2D, 4'h7, to);
    checks++;
    if (to) begin failures++; $display("FAIL rmid_send_timeout"); return; end
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'h00 ||
        bus.remainder !== 4'h0 || bus.div0 !== 1'b0 || bus.exact !== 1'b0) begin
      failures++;
      $display("FAIL rmid_outputs got rdy=%b vld=%b q=%h r=%h d0=%b ex=%b exp rdy=1 vld=0 q=00 r=0 d0=0 ex=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div0, bus.exact);
    end
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad_seen = 1'b1;
    end
    checks++; if (bad_seen) begin failures++; $display("FAIL rmid_abandoned got=out_valid exp=none"); end
    send(8'h2D, 4'h7, to);
    checks++;
    if (to) begin failures++; $display("FAIL rmid_send2_timeout"); return; end
    recv(0, got, lat, to);
    exp = sb.pop_front();
    checks++;
    if (to) begin failures++; $display("FAIL rmid_recv_timeout"); return; end
    checks++; if (got.q !== 8'h06) begin failures++; $display("FAIL rmid_quotient got=%h exp=06", got.q); end
    checks++; if (got.r !== 4'h3)  begin failures++; $display("FAIL rmid_remainder got=%h exp=3", got.r); end
    checks++; if (got !== exp)     begin failures++; $display("FAIL rmid_result got=%h exp=%h", got, exp); end
  endtask

  task automatic test_exhaustive();
    res_t got, exp;
    int   lat;
    int   stall;
    bit   to;
    for (int d = 0; d < 256; d++) begin
      for (int v = 1; v < 16; v++) begin
        send(8'(d), 4'(v), to);
        if (to) begin
          checks++; failures++;
          $display("FAIL exh_send_timeout d=%0d v=%0d", d, v);
          continue;
        end
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        recv(stall, got, lat, to);
        exp = sb.pop_front();
        checks++;
        if (to || got !== exp || lat !== 9) begin
          failures++;
          $display("FAIL exh d=%0d v=%0d got q=%h r=%h d0=%b ex=%b lat=%0d exp q=%h r=%h d0=%b ex=%b lat=9",
                   d, v, got.q, got.r, got.d0, got.ex, lat, exp.q, exp.r, exp.d0, exp.ex);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
